// File: rtl/dmem_store_buffer_pkg.sv
// Shared CPU data-memory constants: store-buffer depth, entry field widths and byte-lane count.
// Also defines the store-buffer entry record.
package dmem_store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_LANES         = 4;
    localparam int SB_DATA_W        = 32;
    localparam int SB_WADDR_W       = 30;

    typedef struct packed {
        logic [SB_WADDR_W-1:0] waddr;
        logic [SB_DATA_W-1:0]  data;
        logic [SB_LANES-1:0]   be;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-byte-lane read forwarding over the buffered stores.
// Each lane takes the newest matching entry, falling back to memory data.
module sb_fwd_merge
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic [SB_WADDR_W-1:0]  raddr,
    input  sb_entry_t [DEPTH-1:0]  entries,
    input  logic [DEPTH-1:0]       valid,
    input  logic [SB_DATA_W-1:0]   mem_rdata,
    output logic [SB_DATA_W-1:0]   rdata
);

    // entries[] arrive oldest-first, so a later match simply overwrites an earlier one
    always_comb begin
        rdata = mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].waddr == raddr)) begin
                for (int l = 0; l < SB_LANES; l++) begin
                    if (entries[i].be[l]) begin
                        rdata[8*l +: 8] = entries[i].data[8*l +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// CPU data-memory store buffer: in-order FIFO of pending word stores drained to memory,
// with byte-lane read forwarding so loads observe stores that have not yet reached memory.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           daddr,
    input  logic [SB_DATA_W-1:0]  dwdata,
    input  logic [SB_LANES-1:0]   dwe,
    output logic [SB_DATA_W-1:0]  drdata,
    output logic [31:0]           mem_raddr,
    input  logic [SB_DATA_W-1:0]  mem_rdata,
    output logic [31:0]           mem_waddr,
    output logic [SB_DATA_W-1:0]  mem_wdata,
    output logic [SB_LANES-1:0]   mem_wbe,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic                  sb_full,
    output logic                  sb_empty,
    output logic                  sb_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          store_mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               store_req;
    logic               drain;
    logic               enq;
    logic               unused_addr_bits;

    sb_entry_t [DEPTH-1:0] age_entries;
    logic      [DEPTH-1:0] age_valid;

    assign store_req = (dwe != '0);
    assign drain     = mem_wvalid && mem_wready;
    // A full buffer still accepts a store when the head leaves at the same edge
    assign enq       = store_req && (!sb_full || drain);

    assign sb_full   = (count == CNT_W'(DEPTH));
    assign sb_empty  = (count == '0);

    assign mem_raddr        = {daddr[31:2], 2'b00};
    assign unused_addr_bits = ^daddr[1:0];

    assign mem_wvalid = !sb_empty;
    assign mem_waddr  = {store_mem[head].waddr, 2'b00};
    assign mem_wdata  = store_mem[head].data;
    assign mem_wbe    = store_mem[head].be;

    // Pointer, occupancy and sticky overflow bookkeeping; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            sb_overflow <= 1'b0;
        end else begin
            if (drain) begin
                head <= head + 1'b1;
            end
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (enq && !drain) begin
                count <= count + 1'b1;
            end else if (drain && !enq) begin
                count <= count - 1'b1;
            end
            if (store_req && !enq) begin
                sb_overflow <= 1'b1;
            end
        end
    end

    // Entry storage carries no reset: validity comes only from head/count
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            store_mem[tail] <= '{waddr: daddr[31:2], data: dwdata, be: dwe};
        end
    end

    // Present entries oldest-first so the merge can let newer stores override older ones
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entries[i] = store_mem[head + PTR_W'(i)];
            age_valid[i]   = (CNT_W'(i) < count);
        end
    end

    sb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd_merge (
        .raddr     (daddr[31:2]),
        .entries   (age_entries),
        .valid     (age_valid),
        .mem_rdata (mem_rdata),
        .rdata     (drdata)
    );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized scoreboard bench for dmem_store_buffer: a queue-based model of the pending stores
// predicts forwarding and flags, and a separate monitor checks every memory write in order.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;
    logic        mem_wvalid;
    logic        mem_wready;
    logic        sb_full;
    logic        sb_empty;
    logic        sb_overflow;

    store_t pending_q[$];
    store_t expect_q[$];
    bit     model_overflow = 1'b0;
    bit     model_live     = 1'b0;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    dmem_store_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .daddr       (daddr),
        .dwdata      (dwdata),
        .dwe         (dwe),
        .drdata      (drdata),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wbe     (mem_wbe),
        .mem_wvalid  (mem_wvalid),
        .mem_wready  (mem_wready),
        .sb_full     (sb_full),
        .sb_empty    (sb_empty),
        .sb_overflow (sb_overflow)
    );

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predicted load data: memory bytes overlaid by every pending store, oldest to newest
    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] mrd);
        logic [31:0] r = mrd;
        foreach (pending_q[k]) begin
            if (pending_q[k].waddr == a[31:2]) begin
                for (int l = 0; l < 4; l++) begin
                    if (pending_q[k].be[l]) r[8*l +: 8] = pending_q[k].data[8*l +: 8];
                end
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input logic [31:0] a, input logic [3:0] be, input logic [31:0] mrd);
        if (!model_live) return;
        compare("mem_raddr", {32'h0, mem_raddr}, {32'h0, a[31:2], 2'b00});
        compare("sb_empty", {63'h0, sb_empty}, {63'h0, pending_q.size() == 0});
        compare("sb_full", {63'h0, sb_full}, {63'h0, pending_q.size() == DEPTH});
        compare("mem_wvalid", {63'h0, mem_wvalid}, {63'h0, pending_q.size() != 0});
        compare("sb_overflow", {63'h0, sb_overflow}, {63'h0, model_overflow});
        if (be == 4'h0) begin
            compare("drdata", {32'h0, drdata}, {32'h0, model_read(a, mrd)});
        end
    endtask

    // One cycle: drive at the falling edge, check mid-cycle, then advance the model at the rising edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                                 input logic rdy, input logic rst, input logic [31:0] mrd,
                                 input bit chk_rd = 1'b0, input logic [31:0] exp_rd = 32'h0);
        bit drain_now;
        @(negedge clk);
        daddr      = a;
        dwdata     = d;
        dwe        = be;
        mem_wready = rdy;
        reset      = rst;
        mem_rdata  = mrd;
        #1;
        checkOutput(a, be, mrd);
        if (chk_rd) compare("directed_drdata", {32'h0, drdata}, {32'h0, exp_rd});
        @(posedge clk);
        if (rst) begin
            pending_q.delete();
            expect_q.delete();
            model_overflow = 1'b0;
            model_live     = 1'b1;
        end else if (model_live) begin
            drain_now = rdy && (pending_q.size() != 0);
            if (drain_now) void'(pending_q.pop_front());
            if (be != 4'h0) begin
                if (pending_q.size() < DEPTH) begin
                    pending_q.push_back('{waddr: a[31:2], data: d, be: be});
                    expect_q.push_back('{waddr: a[31:2], data: d, be: be});
                end else begin
                    model_overflow = 1'b1;
                end
            end
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic rdy);
        applyStimulus(a, d, be, rdy, 1'b0, $urandom);
    endtask

    task automatic idle(input logic rdy);
        applyStimulus($urandom, $urandom, 4'h0, rdy, 1'b0, $urandom);
    endtask

    task automatic doReset();
        applyStimulus($urandom, $urandom, 4'hF, 1'b1, 1'b1, $urandom);
    endtask

    // Monitor: every accepted memory write must match the oldest outstanding accepted store
    initial begin
        store_t e;
        forever begin
            @(negedge clk);
            #2;
            if (model_live && reset === 1'b0 && mem_wvalid === 1'b1 && mem_wready === 1'b1) begin
                if (expect_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL drain_unexpected: got write to 0x%0h, expected none", mem_waddr);
                end else begin
                    e = expect_q.pop_front();
                    compare("drain_waddr", {32'h0, mem_waddr}, {32'h0, e.waddr, 2'b00});
                    compare("drain_wdata", {32'h0, mem_wdata}, {32'h0, e.data});
                    compare("drain_wbe", {60'h0, mem_wbe}, {60'h0, e.be});
                end
            end
        end
    end

    initial begin
        logic [31:0] addr_pool [4];
        addr_pool = '{32'h100, 32'h104, 32'h200, 32'h300};
        reset = 1'b1; daddr = '0; dwdata = '0; dwe = '0; mem_wready = 1'b0; mem_rdata = '0;

        doReset();
        doReset();

        // Full-word store forwarded to a following load
        store(32'h100, 32'hAABBCCDD, 4'hF, 1'b0);
        applyStimulus(32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h12345678, 1'b1, 32'hAABBCCDD);
        compare("directed_waddr", {32'h0, mem_waddr}, {32'h0, 32'h100});

        // Partial stores merged lane by lane over memory data
        doReset();
        store(32'h200, 32'h0000_0011, 4'h1, 1'b0);
        store(32'h200, 32'h0000_2200, 4'h2, 1'b0);
        applyStimulus(32'h202, 32'h0, 4'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'hFFFF2211);

        // Same-address stores: newest forwards, both drain in order
        doReset();
        store(32'h300, 32'd1, 4'hF, 1'b0);
        store(32'h300, 32'd2, 4'hF, 1'b0);
        applyStimulus(32'h300, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd2);
        repeat (3) idle(1'b1);

        // Fill, overflow, then store-with-drain while full
        doReset();
        for (int k = 0; k < 4; k++) store(32'h400 + 32'(k * 4), 32'hA0 + 32'(k), 4'hF, 1'b0);
        store(32'h480, 32'hDEAD, 4'hF, 1'b0);
        store(32'h484, 32'hBEEF, 4'hF, 1'b1);
        idle(1'b0);
        repeat (5) idle(1'b1);

        // Reset discards pending entries even with the drain port ready
        doReset();
        for (int k = 0; k < 3; k++) store(32'h600 + 32'(k * 4), 32'hC0 + 32'(k), 4'hF, 1'b0);
        doReset();
        repeat (3) idle(1'b1);

        // Continuous enqueue and drain across pointer wrap-around
        for (int k = 0; k < 10; k++) store(32'h500 + 32'(k * 4), 32'hE0 + 32'(k), 4'hF, 1'b1);
        repeat (2) idle(1'b1);

        // Randomized traffic over a small address pool to provoke forwarding hits
        for (int n = 0; n < 400; n++) begin
            logic [3:0] be;
            be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            applyStimulus(addr_pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom, be,
                          1'($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0), $urandom);
        end

        repeat (DEPTH + 2) idle(1'b1);
        compare("scoreboard_drained", 64'(expect_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameter DEPTH SHALL default to 4 and set the number of store entries (power of two, 2..16).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high; clears all state.
REQ-005 daddr  input  32  CPU data address; bits [1:0] are ignored for buffering.
REQ-006 dwdata  input  32  CPU store data, already byte-lane aligned.
REQ-007 dwe  input  4  CPU byte write enables; a nonzero value means store, zero means read.
REQ-008 drdata  output  32  read data to the CPU, combinational in the same cycle as daddr.
REQ-009 mem_raddr  output  32  memory read address, equal to {daddr[31:2],2'b00}.
REQ-010 mem_rdata  input  32  memory combinational read data.
REQ-011 mem_waddr, mem_wdata, mem_wbe  output  32/32/4  drain-port word address, data and byte enables of the head entry.
REQ-012 mem_wvalid  output  1  head entry valid; mem_wready  input  1  memory accepts the write this cycle.
REQ-013 sb_full, sb_empty  output  1  occupancy flags; sb_overflow  output  1  sticky store-dropped flag.

Function
REQ-014 The buffer SHALL be a circular FIFO of DEPTH entries {word address[31:2], data[31:0], be[3:0]} with head and tail pointers and an occupancy count of width log2(DEPTH)+1.
REQ-015 A store (dwe!=0) SHALL be enqueued at the rising edge at which it is presented, provided the buffer is not full or a drain occurs at the same edge.
REQ-016 The outputs mem_wvalid, mem_waddr, mem_wdata and mem_wbe SHALL reflect the head entry whenever the count is nonzero; mem_wvalid SHALL be 0 when the buffer is empty.
REQ-017 Drain: when mem_wvalid && mem_wready, the head SHALL advance at that edge; one entry is drained per cycle at most.
REQ-018 A store SHALL have a minimum latency of one cycle from acceptance to mem_wvalid; an empty buffer SHALL NOT bypass a store directly to the drain port.
REQ-019 Simultaneous enqueue and drain SHALL leave the count unchanged, including when the buffer is full.
REQ-020 A store presented while the buffer is full and no drain occurs SHALL be dropped, and sb_overflow SHALL set and remain set until reset.
REQ-021 Pointers SHALL wrap modulo DEPTH; sb_full = (count==DEPTH) and sb_empty = (count==0).
REQ-022 Read forwarding: for each byte lane, drdata SHALL take the byte from the newest valid entry whose word address equals daddr[31:2] and whose be bit is set; otherwise it SHALL take the byte from mem_rdata.
REQ-023 An entry being drained in the current cycle SHALL still participate in forwarding during that cycle.
REQ-024 drdata SHALL be driven (not X) when dwe!=0; its value in that case is don't-care to the CPU.
REQ-025 Entries SHALL NOT be coalesced; memory write order SHALL equal CPU store order.

Reset
REQ-026 On reset, the following SHALL be cleared at the next edge: count, head, tail and sb_overflow; sb_empty SHALL then be 1, and mem_wvalid and sb_full SHALL be 0.
REQ-027 Reset SHALL discard pending entries even if mem_wready is high in the reset cycle, and a store presented in the reset cycle SHALL NOT be enqueued.
REQ-028 Entry storage arrays SHALL NOT require reset; validity is derived solely from the pointers and count.

Structure
REQ-029 DEPTH default, entry field widths and the byte-lane count (4) SHALL live in the shared CPU constants header.
REQ-030 The byte-lane newest-match forwarding logic SHALL be a sub-module named sb_fwd_merge; the FIFO control SHALL remain in dmem_store_buffer.

Verification
REQ-031 Store 0xAABBCCDD, be=4'hF, addr 0x100, mem_wready=0; read 0x100 next cycle -> drdata=0xAABBCCDD; mem_wvalid=1, mem_waddr=0x100.
REQ-032 Stores with be=4'h1 data 0x11 then be=4'h2 data 0x2200 to 0x200, mem_rdata=0xFFFFFFFF; read 0x200 -> drdata=0xFFFF2211.
REQ-033 Issue two stores to 0x300, first with data 1 and then with data 2, both with be=4'hF; read 0x300 -> drdata=2; with mem_wready=1, drains occur in the order data 1 then data 2.
REQ-034 Fill 4 entries with mem_wready=0 so that sb_full=1; a fifth store -> dropped, sb_overflow=1, count=4; then a store with mem_wready=1 in the same cycle -> accepted, count stays 4.
REQ-035 Fill 3 entries, assert reset for one cycle with mem_wready=1 -> next cycle sb_empty=1, mem_wvalid=0, sb_overflow=0, and no further memory writes occur.
REQ-036 With DEPTH=4, enqueue and drain continuously for 10 stores -> correct wrap-around, mem_waddr sequence matches store order, and count stays at most 1.
